// File: rtl/noc_input_port.sv
// -----------------------------------------------------------------------------
// noc_input_port
//
// Receive side of a router's credit-based link. Incoming flits are buffered in
// a DEPTH-entry circular FIFO; the head flit is presented to the crossbar
// together with a one-hot XY route request. A switch grant pops the head, and
// every pop returns exactly one credit upstream on the following cycle.
//
// Ports
//   clk           in   1        clock, rising edge
//   rst           in   1        synchronous active-high reset
//   data_i        in   DATA_W   incoming flit
//   valid_i       in   1        incoming flit valid
//   inc_credit_o  out  1        registered one-cycle credit return pulse
//   req_o         out  5        one-hot route request {W,S,E,N,L}, 0 when empty
//   data_o        out  DATA_W   head flit, 0 when empty
//   grant_i       in   1        switch grant, pops the head flit
//   overflow_o    out  1        sticky: a flit arrived while full with no pop
// -----------------------------------------------------------------------------
module noc_input_port #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 5,
    parameter int COORD_W = 2,
    parameter int MY_X    = 0,
    parameter int MY_Y    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              inc_credit_o,
    output logic [4:0]        req_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              grant_i,
    output logic              overflow_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]   PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [OCC_W-1:0]   OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0]   OCC_ZERO = {OCC_W{1'b0}};
    localparam logic [OCC_W-1:0]   OCC_ONE  = {{(OCC_W-1){1'b0}}, 1'b1};
    localparam logic [COORD_W-1:0] MY_X_C   = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_Y_C   = COORD_W'(MY_Y);

    // One-hot request encodings, bit order {W,S,E,N,L}
    localparam logic [4:0] REQ_L    = 5'b00001;
    localparam logic [4:0] REQ_N    = 5'b00010;
    localparam logic [4:0] REQ_E    = 5'b00100;
    localparam logic [4:0] REQ_S    = 5'b01000;
    localparam logic [4:0] REQ_W    = 5'b10000;
    localparam logic [4:0] REQ_NONE = 5'b00000;

    // Circular pointer advance; DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = PTR_ZERO;
        end else begin
            nxt = ptr + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // Dimension-ordered XY routing: resolve X first, then Y, else eject locally.
    function automatic logic [4:0] route_req(input logic [DATA_W-1:0] flit);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        logic [4:0]         req;
        dx = flit[DATA_W-1 -: COORD_W];
        dy = flit[DATA_W-COORD_W-1 -: COORD_W];
        if (dx > MY_X_C) begin
            req = REQ_E;
        end else if (dx < MY_X_C) begin
            req = REQ_W;
        end else if (dy > MY_Y_C) begin
            req = REQ_N;
        end else if (dy < MY_Y_C) begin
            req = REQ_S;
        end else begin
            req = REQ_L;
        end
        return req;
    endfunction

    // Storage is deliberately left without reset; occupancy alone decides validity.
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             r_inc_credit;
    logic             r_overflow;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [DATA_W-1:0] w_head;
    logic [4:0]        w_req;

    // Push/pop qualification: a pop frees a slot in the same edge, so a FULL
    // FIFO still accepts a flit when the head is being granted.
    always_comb begin
        w_empty = 1'b0;
        w_full  = 1'b0;
        w_pop   = 1'b0;
        w_push  = 1'b0;
        w_drop  = 1'b0;
        if (r_occ == OCC_ZERO) begin
            w_empty = 1'b1;
        end else begin
            w_empty = 1'b0;
        end
        if (r_occ == OCC_FULL) begin
            w_full = 1'b1;
        end else begin
            w_full = 1'b0;
        end
        w_pop  = grant_i & ~w_empty;
        w_push = valid_i & (~w_full | w_pop);
        w_drop = valid_i & w_full & ~w_pop;
    end

    // Head flit and route request; both forced to zero while the FIFO is empty.
    always_comb begin
        w_head = {DATA_W{1'b0}};
        w_req  = REQ_NONE;
        if (w_empty) begin
            w_head = {DATA_W{1'b0}};
            w_req  = REQ_NONE;
        end else begin
            w_head = r_mem[r_rd_ptr];
            w_req  = route_req(r_mem[r_rd_ptr]);
        end
    end

    // Flit storage write port.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers, occupancy, credit pulse and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= PTR_ZERO;
            r_rd_ptr     <= PTR_ZERO;
            r_occ        <= OCC_ZERO;
            r_inc_credit <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_ONE;
                2'b01:   r_occ <= r_occ - OCC_ONE;
                default: r_occ <= r_occ;
            endcase
            // One credit per popped flit; dropped flits never earn one.
            r_inc_credit <= w_pop;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign inc_credit_o = r_inc_credit;
    assign overflow_o   = r_overflow;
    assign data_o       = w_head;
    assign req_o        = w_req;

endmodule
